// File: rtl/down_timer.sv
// down_timer: loadable down-counting timer with start/done handshake.
//
// The timer is loaded with a terminal count, started, and decrements once per
// unpaused clock while in RUN. Reaching zero raises a one-cycle done pulse and
// returns to IDLE. If DOWN_TIMER_AUTORELOAD_EN is defined, the terminal step
// reloads the count from the reload register instead and stays in RUN, which
// turns done into a periodic tick.
//
// Parameters:
//   WIDTH     width of the count and load value (default 8)
// Ports:
//   clk       clock, rising edge
//   reset     synchronous, active-high reset
//   load      capture load_val into count and reload; aborts any run
//   load_val  value captured on load
//   start     begin counting from the current count (IDLE only)
//   pause     hold the count for this cycle while in RUN
//   count     current count (registered)
//   busy      high while in RUN (registered)
//   done      one-cycle registered pulse on terminal count
//
// Configuration macro: DOWN_TIMER_AUTORELOAD_EN

module down_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] count_next;
    logic             busy_next;
    logic             done_next;

`ifdef DOWN_TIMER_AUTORELOAD_EN
    logic [WIDTH-1:0] reload;
    logic [WIDTH-1:0] reload_next;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            count  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
`ifdef DOWN_TIMER_AUTORELOAD_EN
            reload <= '0;
`endif
        end else begin
            state  <= state_next;
            count  <= count_next;
            busy   <= busy_next;
            done   <= done_next;
`ifdef DOWN_TIMER_AUTORELOAD_EN
            reload <= reload_next;
`endif
        end
    end

    always_comb begin
        state_next  = state;
        count_next  = count;
        done_next   = 1'b0;
`ifdef DOWN_TIMER_AUTORELOAD_EN
        reload_next = reload;
`endif

        if (load) begin
            // load outranks start and the terminal step: a coincident
            // terminal step produces no done.
            count_next  = load_val;
            state_next  = IDLE;
`ifdef DOWN_TIMER_AUTORELOAD_EN
            reload_next = load_val;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (count != '0) begin
                            state_next = RUN;
                        end else begin
                            // Zero-length run: report completion immediately.
                            done_next = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (!pause) begin
                        if (count > WIDTH'(1)) begin
                            count_next = count - WIDTH'(1);
                        end else begin
                            // Terminal step; count is never 0 in RUN, so
                            // this is count == 1 and cannot underflow.
                            done_next = 1'b1;
`ifdef DOWN_TIMER_AUTORELOAD_EN
                            count_next = reload;
`else
                            count_next = '0;
                            state_next = IDLE;
`endif
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end

        busy_next = (state_next == RUN);
    end

endmodule

// File: tb/tb_down_timer.sv
// tb_down_timer: self-checking bench for down_timer (WIDTH = 8).
// One-shot behaviour is exercised by a vector table; reset mid-run, load on
// the terminal edge and (when DOWN_TIMER_AUTORELOAD_EN is defined) the
// periodic reload are exercised by hand-written sequences.

module tb_down_timer;

    localparam int unsigned W = 8;

    logic         clk;
    logic         reset;
    logic         load;
    logic [W-1:0] load_val;
    logic         start;
    logic         pause;
    logic [W-1:0] count;
    logic         busy;
    logic         done;

    int passed;
    int total;

    down_timer #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .pause    (pause),
        .count    (count),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One record = inputs applied for one rising edge and the outputs
    // required just after that edge.
    typedef struct {
        string        name;
        logic         rst;
        logic         ld;
        logic [W-1:0] lv;
        logic         st;
        logic         ps;
        logic [W-1:0] e_count;
        logic         e_busy;
        logic         e_done;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string name, input logic rst, input logic ld,
                       input logic [W-1:0] lv, input logic st, input logic ps,
                       input logic [W-1:0] ec, input logic eb, input logic ed);
        vec_t v;
        v.name = name; v.rst = rst; v.ld = ld; v.lv = lv; v.st = st; v.ps = ps;
        v.e_count = ec; v.e_busy = eb; v.e_done = ed;
        vecs.push_back(v);
    endtask

    // Drive inputs away from the edge, clock once, sample 1 time unit later.
    task automatic step(input logic rst, input logic ld, input logic [W-1:0] lv,
                        input logic st, input logic ps);
        @(negedge clk);
        reset = rst; load = ld; load_val = lv; start = st; pause = ps;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [W-1:0] ec,
                         input logic eb, input logic ed);
        total++;
        if (count === ec && busy === eb && done === ed) begin
            passed++;
        end else begin
            $display("FAIL %s: got count=%0d busy=%b done=%b, want count=%0d busy=%b done=%b",
                     name, count, busy, done, ec, eb, ed);
        end
    endtask

    task automatic idle(input int n, input string name, input logic [W-1:0] ec,
                        input logic eb, input logic ed);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, '0, 1'b0, 1'b0);
            check(name, ec, eb, ed);
        end
    endtask

    initial begin
        passed = 0;
        total  = 0;
        reset = 1'b1; load = 1'b0; load_val = '0; start = 1'b0; pause = 1'b0;

`ifndef DOWN_TIMER_AUTORELOAD_EN
        //   name           rst ld lv st ps  count busy done
        add("reset",         1, 0, 0, 0, 0,  0, 0, 0);
        add("start_zero",    0, 0, 0, 1, 0,  0, 0, 1);
        add("start_zero+1",  0, 0, 0, 0, 0,  0, 0, 0);
        // Run from 5: done appears 6 edges after start (inclusive of start).
        add("load5",         0, 1, 5, 0, 0,  5, 0, 0);
        add("start5",        0, 0, 0, 1, 0,  5, 1, 0);
        add("run5_e1",       0, 0, 0, 0, 0,  4, 1, 0);
        add("run5_e2",       0, 0, 0, 0, 0,  3, 1, 0);
        add("run5_e3",       0, 0, 0, 0, 0,  2, 1, 0);
        add("run5_e4",       0, 0, 0, 0, 0,  1, 1, 0);
        add("run5_done",     0, 0, 0, 0, 0,  0, 0, 1);
        add("run5_after",    0, 0, 0, 0, 0,  0, 0, 0);
        add("run5_hold",     0, 0, 0, 0, 1,  0, 0, 0);
        // Run from 4 with 3 paused cycles: done 4+1+3 = 8 edges after start.
        add("load4",         0, 1, 4, 0, 0,  4, 0, 0);
        add("start4",        0, 0, 0, 1, 0,  4, 1, 0);
        add("run4_e1",       0, 0, 0, 0, 0,  3, 1, 0);
        add("pause_1",       0, 0, 0, 0, 1,  3, 1, 0);
        add("pause_2",       0, 0, 0, 0, 1,  3, 1, 0);
        add("pause_3",       0, 0, 0, 0, 1,  3, 1, 0);
        add("run4_e5",       0, 0, 0, 0, 0,  2, 1, 0);
        add("run4_e6",       0, 0, 0, 0, 0,  1, 1, 0);
        add("run4_done",     0, 0, 0, 0, 0,  0, 0, 1);
        add("run4_after",    0, 0, 0, 0, 0,  0, 0, 0);
        // Start held high during a run from 7: ignored, done at edge 8.
        add("load7",         0, 1, 7, 0, 0,  7, 0, 0);
        add("start7",        0, 0, 0, 1, 0,  7, 1, 0);
        add("restart_e1",    0, 0, 0, 1, 0,  6, 1, 0);
        add("restart_e2",    0, 0, 0, 1, 0,  5, 1, 0);
        add("run7_e3",       0, 0, 0, 0, 0,  4, 1, 0);
        add("restart_e4",    0, 0, 0, 1, 0,  3, 1, 0);
        add("run7_e5",       0, 0, 0, 0, 0,  2, 1, 0);
        add("run7_e6",       0, 0, 0, 0, 0,  1, 1, 0);
        add("run7_done",     0, 0, 0, 0, 0,  0, 0, 1);
        add("run7_after",    0, 0, 0, 0, 0,  0, 0, 0);
        // Load beats a simultaneous start; pause is ignored in IDLE.
        add("load_start",    0, 1, 2, 1, 0,  2, 0, 0);
        add("idle_pause",    0, 0, 0, 0, 1,  2, 0, 0);
        add("start_pause",   0, 0, 0, 1, 1,  2, 1, 0);
        add("run2_paused",   0, 0, 0, 0, 1,  2, 1, 0);
        add("run2_e1",       0, 0, 0, 0, 0,  1, 1, 0);
        add("run2_done",     0, 0, 0, 0, 0,  0, 0, 1);
        add("run2_after",    0, 0, 0, 0, 0,  0, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].ld, vecs[i].lv, vecs[i].st, vecs[i].ps);
            check(vecs[i].name, vecs[i].e_count, vecs[i].e_busy, vecs[i].e_done);
        end
`else
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        check("reset", 0, 0, 0);
        // Periodic tick with period 3: count 3,2,1,3,2,1 ...
        step(1'b0, 1'b1, 8'd3, 1'b0, 1'b0);
        check("ar_load3", 3, 0, 0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        check("ar_start", 3, 1, 0);
        for (int p = 0; p < 3; p++) begin
            idle(1, "ar_cnt2", 2, 1, 0);
            idle(1, "ar_cnt1", 1, 1, 0);
            idle(1, "ar_tick", 3, 1, 1);
        end
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        check("ar_pause", 3, 1, 0);
        step(1'b0, 1'b1, 8'd0, 1'b0, 1'b0);
        check("ar_load0", 0, 0, 0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        check("ar_start_zero", 0, 0, 1);
        idle(2, "ar_idle", 0, 0, 0);
`endif

        // Reset mid-run from 10 when count reaches 6: run abandoned, no done.
        step(1'b0, 1'b1, 8'd10, 1'b0, 1'b0);
        check("load10", 10, 0, 0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        check("start10", 10, 1, 0);
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        end
        check("run10_at6", 6, 1, 0);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        check("reset_midrun", 0, 0, 0);
        idle(7, "after_reset", 0, 0, 0);

        // Load on the terminal edge wins: no done, back to IDLE with count 3.
        step(1'b0, 1'b1, 8'd3, 1'b0, 1'b0);
        check("load3", 3, 0, 0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        check("start3", 3, 1, 0);
        idle(1, "run3_e1", 2, 1, 0);
        idle(1, "run3_e2", 1, 1, 0);
        step(1'b0, 1'b1, 8'd3, 1'b0, 1'b0);
        check("load_on_terminal", 3, 0, 0);
        idle(2, "idle_after_load", 3, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
